// File: rtl/cam_simd_pkg.sv
// Shared types and constants for the cam_simd host sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cam_simd_pkg;

  localparam int CAM_ENTRIES = 8;
  localparam int CAM_DATA_W  = 4;
  localparam int CAM_RES_W   = 6;
  localparam int CAM_IDX_W   = 3;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_FILL   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_READY  = 3'd2,
    ST_SEARCH = 3'd3,
    ST_DRAIN  = 3'd4
  } seq_state_e;

  // Truth tables loaded into the function CAM, indexed {R bit, L bit}.
  localparam logic [3:0]  TT_AND = 4'h8;
  localparam logic [7:0]  TT_OR  = 8'hE0;
  localparam logic [11:0] TT_XOR = 12'h600;

endpackage

// File: rtl/cam_simd_result_buf.sv
// Captures all CAM result rows in one strobe and drains them in index order.
// Latency: first row valid the cycle after capture; one row per handshake.
// Backpressure: row held stable while res_ready is low.
// Ports: capture/rows_in load the buffer; res_* is the valid/ready row stream;
//        done pulses with the handshake of the last row.
module cam_simd_result_buf
  import cam_simd_pkg::*;
#(
  parameter int NUM_ENTRIES = CAM_ENTRIES,
  parameter int RES_W       = CAM_RES_W,
  parameter int IDX_W       = CAM_IDX_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         capture,
  input  logic [NUM_ENTRIES*RES_W-1:0] rows_in,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [RES_W-1:0]             res_data,
  output logic [IDX_W-1:0]             res_idx,
  output logic                         res_last,
  output logic                         done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  logic [NUM_ENTRIES*RES_W-1:0] rows;
  logic [IDX_W-1:0]             ptr;
  logic                         vld;
  logic                         hs;
  logic                         at_last;

  assign hs      = vld && res_ready;
  assign at_last = (ptr == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rows <= '0;
      ptr  <= '0;
      vld  <= 1'b0;
    end else if (capture) begin
      rows <= rows_in;
      ptr  <= '0;
      vld  <= 1'b1;
    end else if (hs) begin
      if (at_last) begin
        vld <= 1'b0;
        ptr <= '0;
      end else begin
        ptr <= ptr + 1'b1;
      end
    end
  end

  // Data is forced to zero when idle so a drained buffer looks like reset.
  assign res_valid = vld;
  assign res_data  = vld ? rows[ptr*RES_W +: RES_W] : '0;
  assign res_idx   = ptr;
  assign res_last  = vld && at_last;
  assign done      = hs && at_last;

endmodule

// File: rtl/cam_simd_seq.sv
// Host sequencer: gathers 8 operand pairs, loads the CAMs, issues searches, streams results.
// Latency: load pulse 1 cycle after 8th beat; results valid SEARCH_LAT+1 cycles after command.
// Backpressure: in/op streams stalled by in_ready/op_ready; result rows held until res_ready.
// Ports: in_* operand stream; op_*/key_* search commands; op_err reserved-opcode pulse;
//        res_* result rows; cam_* drive the cam_simd array, cam_op_reg returns its rows.
module cam_simd_seq
  import cam_simd_pkg::*;
#(
  parameter int NUM_ENTRIES = CAM_ENTRIES,
  parameter int DATA_W      = CAM_DATA_W,
  parameter int RES_W       = CAM_RES_W,
  parameter int SEARCH_LAT  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_l,
  input  logic [DATA_W-1:0]             in_r,
  input  logic                          op_valid,
  output logic                          op_ready,
  input  logic [1:0]                    op_code,
  input  logic [DATA_W-1:0]             key_l,
  input  logic [DATA_W-1:0]             key_r,
  output logic                          op_err,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [RES_W-1:0]              res_data,
  output logic [2:0]                    res_idx,
  output logic                          res_last,
  output logic                          cam_write_en,
  output logic [NUM_ENTRIES*DATA_W-1:0] cam_data_L,
  output logic [NUM_ENTRIES*DATA_W-1:0] cam_data_R,
  output logic [3:0]                    cam_data_and,
  output logic [7:0]                    cam_data_or,
  output logic [11:0]                   cam_data_xor,
  output logic [DATA_W-1:0]             cam_pe_reg_L,
  output logic [DATA_W-1:0]             cam_pe_reg_R,
  output logic [1:0]                    cam_controller,
  input  logic [NUM_ENTRIES*RES_W-1:0]  cam_op_reg
);

  localparam logic [3:0] LAT_LAST  = 4'(SEARCH_LAT - 1);
  localparam logic [2:0] FILL_LAST = 3'(NUM_ENTRIES - 1);

  seq_state_e state;
  logic [2:0] fill_cnt;
  logic [3:0] lat_cnt;
  logic       beat_acc;
  logic       cmd_acc;
  logic       cmd_rsvd;
  logic       capture;
  logic       drain_done;

  // A command has priority over an operand beat presented in the same READY cycle.
  assign in_ready     = (state == ST_FILL) || ((state == ST_READY) && !op_valid);
  assign op_ready     = (state == ST_READY);
  assign cam_write_en = (state == ST_LOAD);

  assign beat_acc = in_valid && in_ready;
  assign cmd_acc  = op_valid && op_ready;
  assign cmd_rsvd = cmd_acc && (op_code == OP_RSVD);
  assign capture  = (state == ST_SEARCH) && (lat_cnt == LAT_LAST);

  assign cam_data_and = TT_AND;
  assign cam_data_or  = TT_OR;
  assign cam_data_xor = TT_XOR;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_FILL;
      fill_cnt       <= '0;
      lat_cnt        <= '0;
      cam_data_L     <= '0;
      cam_data_R     <= '0;
      cam_pe_reg_L   <= '0;
      cam_pe_reg_R   <= '0;
      cam_controller <= 2'b00;
      op_err         <= 1'b0;
    end else begin
      op_err <= cmd_rsvd;
      case (state)
        ST_FILL: begin
          if (beat_acc) begin
            cam_data_L[fill_cnt*DATA_W +: DATA_W] <= in_l;
            cam_data_R[fill_cnt*DATA_W +: DATA_W] <= in_r;
            if (fill_cnt == FILL_LAST) begin
              fill_cnt <= '0;
              state    <= ST_LOAD;
            end else begin
              fill_cnt <= fill_cnt + 3'd1;
            end
          end
        end
        ST_LOAD: state <= ST_READY;
        ST_READY: begin
          if (cmd_acc) begin
            // Reserved opcode only raises op_err; CAM-facing registers stay put.
            if (!cmd_rsvd) begin
              cam_pe_reg_L   <= key_l;
              cam_pe_reg_R   <= key_r;
              cam_controller <= op_code;
              lat_cnt        <= '0;
              state          <= ST_SEARCH;
            end
          end else if (beat_acc) begin
            // New image starts at entry 0; the CAM keeps the old one until the next LOAD.
            cam_data_L[DATA_W-1:0] <= in_l;
            cam_data_R[DATA_W-1:0] <= in_r;
            fill_cnt               <= 3'd1;
            state                  <= ST_FILL;
          end
        end
        ST_SEARCH: begin
          if (capture) begin
            state <= ST_DRAIN;
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            state <= ST_READY;
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

  cam_simd_result_buf #(
    .NUM_ENTRIES(NUM_ENTRIES),
    .RES_W      (RES_W),
    .IDX_W      (3)
  ) u_result_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .capture  (capture),
    .rows_in  (cam_op_reg),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_idx  (res_idx),
    .res_last (res_last),
    .done     (drain_done)
  );

endmodule

// File: tb/tb_cam_simd_seq.sv
// Bench for cam_simd_seq: directed stimulus, result rows checked by a queue-driven monitor.
// Latency: checks load pulse timing and SEARCH_LAT+1 result latency.
// Backpressure: stalls the result stream mid-drain.
module tb_cam_simd_seq;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [3:0]  in_l, in_r;
  logic        op_valid, op_ready;
  logic [1:0]  op_code;
  logic [3:0]  key_l, key_r;
  logic        op_err;
  logic        res_valid, res_ready;
  logic [5:0]  res_data;
  logic [2:0]  res_idx;
  logic        res_last;
  logic        cam_write_en;
  logic [31:0] cam_data_L, cam_data_R;
  logic [3:0]  cam_data_and;
  logic [7:0]  cam_data_or;
  logic [11:0] cam_data_xor;
  logic [3:0]  cam_pe_reg_L, cam_pe_reg_R;
  logic [1:0]  cam_controller;
  logic [47:0] cam_op_reg;

  always #5 clk = ~clk;

  cam_simd_seq #(
    .NUM_ENTRIES(8), .DATA_W(4), .RES_W(6), .SEARCH_LAT(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_l(in_l), .in_r(in_r),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .key_l(key_l), .key_r(key_r), .op_err(op_err),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_idx(res_idx), .res_last(res_last),
    .cam_write_en(cam_write_en), .cam_data_L(cam_data_L), .cam_data_R(cam_data_R),
    .cam_data_and(cam_data_and), .cam_data_or(cam_data_or), .cam_data_xor(cam_data_xor),
    .cam_pe_reg_L(cam_pe_reg_L), .cam_pe_reg_R(cam_pe_reg_R),
    .cam_controller(cam_controller), .cam_op_reg(cam_op_reg)
  );

  typedef struct packed {
    logic [5:0] data;
    logic [2:0] idx;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // CAM model: row n = n*mult + add.
  task automatic set_cam(input int mult, input int add);
    for (int n = 0; n < 8; n++) cam_op_reg[n*6 +: 6] = 6'(n * mult + add);
  endtask

  task automatic push_rows(input int mult, input int add, input int count);
    exp_t e;
    for (int n = 0; n < count; n++) begin
      e.data = 6'(n * mult + add);
      e.idx  = 3'(n);
      e.last = (n == 7);
      exp_q.push_back(e);
    end
  endtask

  task automatic fill(input logic [31:0] li, input logic [31:0] ri, input int n);
    for (int i = 0; i < n; i++) begin
      step;
      in_valid = 1'b1;
      in_l     = li[i*4 +: 4];
      in_r     = ri[i*4 +: 4];
      @(negedge clk);
      chk("fill_in_ready", in_ready, 1'b1);
      chk("fill_no_write", cam_write_en, 1'b0);
    end
    step;
    in_valid = 1'b0;
  endtask

  task automatic issue(input logic [1:0] code, input logic [3:0] kl, input logic [3:0] kr);
    step;
    op_valid = 1'b1;
    op_code  = code;
    key_l    = kl;
    key_r    = kr;
    @(negedge clk);
    chk("cmd_op_ready", op_ready, 1'b1);
    chk("cmd_in_ready_low", in_ready, 1'b0);
    step;
    op_valid = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int c;
    for (c = 0; c < 40; c++) begin
      @(negedge clk);
      if (op_ready) break;
    end
    chk(name, (c < 40), 1'b1);
  endtask

  task automatic wait_idx(input string name, input logic [2:0] idx);
    int c;
    for (c = 0; c < 20; c++) begin
      @(negedge clk);
      if (res_valid && res_idx == idx) break;
    end
    chk(name, (c < 20), 1'b1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk({tag, "_op_ready"}, op_ready, 1'b0);
    chk({tag, "_op_err"}, op_err, 1'b0);
    chk({tag, "_res_valid"}, res_valid, 1'b0);
    chk({tag, "_res_idx"}, res_idx, 3'd0);
    chk({tag, "_res_last"}, res_last, 1'b0);
    chk({tag, "_res_data"}, res_data, 6'd0);
    chk({tag, "_write_en"}, cam_write_en, 1'b0);
    chk({tag, "_data_L"}, cam_data_L, 32'h0);
    chk({tag, "_data_R"}, cam_data_R, 32'h0);
    chk({tag, "_pe_L"}, cam_pe_reg_L, 4'h0);
    chk({tag, "_pe_R"}, cam_pe_reg_R, 4'h0);
    chk({tag, "_ctrl"}, cam_controller, 2'b00);
    chk({tag, "_tt_and"}, cam_data_and, 4'h8);
    chk({tag, "_tt_or"}, cam_data_or, 8'hE0);
    chk({tag, "_tt_xor"}, cam_data_xor, 12'h600);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_l       = '0;
    in_r       = '0;
    op_valid   = 1'b0;
    op_code    = 2'b00;
    key_l      = '0;
    key_r      = '0;
    res_ready  = 1'b0;
    cam_op_reg = '0;

    // Result monitor: pops an expected row on every handshake.
    fork
      forever begin
        @(negedge clk);
        if (res_valid && res_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_row: got idx %0d data %0d, want no row", res_idx, res_data);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("row_data", res_data, e.data);
            chk("row_idx", res_idx, e.idx);
            chk("row_last", res_last, e.last);
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("rst");
    step;
    rst_n = 1'b1;

    // 1: initial fill and load pulse
    fill(32'h76543210, 32'h01234567, 8);
    @(negedge clk);
    chk("load_write_en", cam_write_en, 1'b1);
    chk("load_in_ready", in_ready, 1'b0);
    chk("load_L3", cam_data_L[15:12], 4'd3);
    chk("load_R3", cam_data_R[15:12], 4'd4);
    chk("load_L_img", cam_data_L, 32'h76543210);
    chk("load_R_img", cam_data_R, 32'h01234567);
    @(negedge clk);
    chk("post_load_write_en", cam_write_en, 1'b0);
    chk("post_load_op_ready", op_ready, 1'b1);

    // 2: AND search, no stalls
    res_ready = 1'b1;
    set_cam(3, 0);
    push_rows(3, 0, 8);
    issue(2'b00, 4'd5, 4'd2);
    @(negedge clk);
    chk("srch_pe_L", cam_pe_reg_L, 4'd5);
    chk("srch_pe_R", cam_pe_reg_R, 4'd2);
    chk("srch_ctrl", cam_controller, 2'b00);
    chk("srch_write_en", cam_write_en, 1'b0);
    chk("srch_op_ready", op_ready, 1'b0);
    chk("srch_res_valid_t1", res_valid, 1'b0);
    step;
    @(negedge clk);
    chk("srch_res_valid_t2", res_valid, 1'b0);
    step;
    @(negedge clk);
    chk("srch_res_valid_t3", res_valid, 1'b1);
    chk("srch_first_idx", res_idx, 3'd0);
    wait_ready("drain1_done");
    chk("drain1_valid_low", res_valid, 1'b0);
    chk("drain1_q_empty", exp_q.size(), 0);

    // 3: XOR search with a 5-cycle stall at row 4
    set_cam(5, 1);
    push_rows(5, 1, 8);
    issue(2'b10, 4'd9, 4'd6);
    wait_idx("stall_reach_row3", 3'd3);
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_idx", res_idx, 3'd4);
      chk("stall_data", res_data, 6'd21);
      chk("stall_valid", res_valid, 1'b1);
      @(posedge clk);
    end
    #1;
    res_ready = 1'b1;
    wait_ready("drain2_done");
    chk("drain2_ctrl", cam_controller, 2'b10);
    chk("drain2_valid_low", res_valid, 1'b0);
    chk("drain2_q_empty", exp_q.size(), 0);

    // 4: command and operand beat together; command wins
    set_cam(2, 7);
    push_rows(2, 7, 8);
    step;
    op_valid = 1'b1;
    op_code  = 2'b00;
    key_l    = 4'd3;
    key_r    = 4'd3;
    in_valid = 1'b1;
    in_l     = 4'hF;
    in_r     = 4'hF;
    @(negedge clk);
    chk("both_in_ready", in_ready, 1'b0);
    chk("both_op_ready", op_ready, 1'b1);
    step;
    op_valid = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("both_L_img", cam_data_L, 32'h76543210);
    chk("both_R_img", cam_data_R, 32'h01234567);
    chk("both_pe_L", cam_pe_reg_L, 4'd3);
    chk("both_in_search", op_ready, 1'b0);
    wait_ready("drain3_done");
    chk("drain3_q_empty", exp_q.size(), 0);

    // 5: reserved opcode
    step;
    op_valid = 1'b1;
    op_code  = 2'b11;
    key_l    = 4'd1;
    key_r    = 4'd1;
    @(negedge clk);
    chk("rsvd_op_ready", op_ready, 1'b1);
    chk("rsvd_err_before", op_err, 1'b0);
    step;
    op_valid = 1'b0;
    @(negedge clk);
    chk("rsvd_err_pulse", op_err, 1'b1);
    chk("rsvd_op_ready_after", op_ready, 1'b1);
    chk("rsvd_ctrl", cam_controller, 2'b00);
    chk("rsvd_pe_L", cam_pe_reg_L, 4'd3);
    @(negedge clk);
    chk("rsvd_err_cleared", op_err, 1'b0);
    chk("rsvd_no_search", op_ready, 1'b1);
    chk("rsvd_no_result", res_valid, 1'b0);

    // 6a: reset while row 3 is pending in DRAIN
    set_cam(1, 0);
    push_rows(1, 0, 3);
    issue(2'b01, 4'd4, 4'd4);
    wait_idx("rst_reach_row2", 3'd2);
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    rst_n     = 1'b0;
    step;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset("rst_drain");
    chk("rst_drain_q_empty", exp_q.size(), 0);
    res_ready = 1'b1;

    // 6b: reset after 5 fill beats, then a full fresh fill
    fill(32'h99999999, 32'h55555555, 5);
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset("rst_fill");
    fill(32'h89ABCDEF, 32'hFEDCBA98, 8);
    @(negedge clk);
    chk("refill_write_en", cam_write_en, 1'b1);
    chk("refill_L_img", cam_data_L, 32'h89ABCDEF);
    chk("refill_R_img", cam_data_R, 32'hFEDCBA98);
    @(negedge clk);
    chk("refill_write_done", cam_write_en, 1'b0);
    chk("refill_op_ready", op_ready, 1'b1);
    chk("final_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cam_simd_seq.md
Name: cam_simd_seq

Overview:
- Host-side sequencer and loader for the cam_simd compute array.
- Collects eight L/R operand pairs over a valid/ready stream. Then loads both operand CAMs and the AND/OR/XOR truth-table CAM with a single-cycle write pulse.
- Issues search commands (key pair + opcode) and holds them for a fixed latency. It then captures the eight 6-bit result rows and streams them back out with backpressure.
- This block is the writer/initiator end of the CAM interface; cam_simd is the responder.

Parameters:
- NUM_ENTRIES, 8, CAM rows per side; also the number of result rows.
- DATA_W, 4, operand/key width.
- RES_W, 6, result row width.
- SEARCH_LAT, 2, cycles keys/opcode are held with write disabled before results are sampled; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  operand pair accepted when high with in_valid.
- in_l  in  DATA_W  L operand.
- in_r  in  DATA_W  R operand.
- op_valid  in  1  search command valid.
- op_ready  out  1  search command accepted when high with op_valid.
- op_code  in  2  00 AND, 01 OR, 10 XOR, 11 reserved.
- key_l  in  DATA_W  L search key.
- key_r  in  DATA_W  R search key.
- op_err  out  1  one-cycle pulse: reserved opcode rejected.
- res_valid  out  1  result row valid.
- res_ready  in  1  result consumer ready.
- res_data  out  RES_W  result row.
- res_idx  out  3  row index 0..7.
- res_last  out  1  high with row 7.
- cam_write_en  out  1  CAM load strobe.
- cam_data_L  out  DATA_W x NUM_ENTRIES  L CAM image.
- cam_data_R  out  DATA_W x NUM_ENTRIES  R CAM image.
- cam_data_and  out  4  AND truth table.
- cam_data_or  out  8  OR truth table.
- cam_data_xor  out  12  XOR truth table.
- cam_pe_reg_L  out  DATA_W  L key to CAM.
- cam_pe_reg_R  out  DATA_W  R key to CAM.
- cam_controller  out  2  opcode to CAM.
- cam_op_reg  in  RES_W x NUM_ENTRIES  result rows from CAM.

Behaviour:
- Clocking and reset:
  - Single clock clk.
  - rst_n is synchronous active-low and overrides everything.
  - After reset: state FILL, fill count 0.
  - Output reset values: in_ready=1, op_ready=0, op_err=0, res_valid=0, res_idx=0, res_last=0, res_data=0, cam_write_en=0, cam_data_L/R all 0, cam_pe_reg_L/R=0, cam_controller=00.
- Truth-table outputs are constants at all times, including reset: cam_data_and=4'h8, cam_data_or=8'hE0, cam_data_xor=12'h600. Each table is indexed {R bit, L bit}.
- FILL:
  - in_ready=1.
  - Each accepted beat writes in_l/in_r into cam_data_L/R[count]; count increments.
  - The edge accepting beat 8 (count 7) moves to LOAD; count returns to 0.
- LOAD:
  - Exactly one cycle with cam_write_en=1, buses stable; in_ready=0.
  - Next state READY.
- READY:
  - op_ready=1.
  - in_ready = !op_valid; a command wins over a simultaneous operand beat.
  - Accepted beat: store it as entry 0, count=1, go to FILL. The old image is overwritten progressively; no CAM write occurs until the new 8th beat.
  - Accepted command with op_code 11: op_err=1 for the next cycle, stay READY, CAM outputs unchanged.
  - Accepted command with any other op_code: register key_l/key_r/op_code onto cam_pe_reg_L/R/cam_controller, go to SEARCH.
- SEARCH:
  - Lasts exactly SEARCH_LAT cycles; cam_write_en=0; in_ready=op_ready=0.
  - Keys and opcode stay held through SEARCH and DRAIN.
  - The edge ending the last SEARCH cycle captures all 8 cam_op_reg rows into the result buffer and enters DRAIN.
  - If the command is accepted at edge T, res_valid is first high in cycle T+SEARCH_LAT+1.
- DRAIN:
  - Rows are emitted in index order 0..7; res_last=1 with row 7.
  - A row advances only on res_valid&&res_ready.
  - res_data/res_idx stay stable while stalled.
  - After row 7 handshakes: res_valid=0 the next cycle, state READY.
  - Captured values are passed through bit-exact and are never recomputed.
- Reset mid-operation (any state): next cycle matches the reset values above; partial fill and buffered results are discarded.
- No command is accepted before the first LOAD completes; op_ready=0 in FILL.

Decomposition:
- Package cam_simd_pkg:
  - op_e enum (OP_AND, OP_OR, OP_XOR, OP_RSVD).
  - Truth-table constants TT_AND, TT_OR, TT_XOR.
  - seq_state_e (FILL, LOAD, READY, SEARCH, DRAIN).
  - Width constants.
- Sub-module cam_simd_result_buf:
  - 8xRES_W capture register with drain pointer, valid/ready output and last flag.
  - Inputs are a capture strobe and the row array.

Test Plan:
1. Reset, then feed L=0..7, R=7..0 with no stalls: cam_write_en is high exactly 1 cycle after the 8th beat; cam_data_L[3]=3, cam_data_R[3]=4; tables read 8/E0/600.
2. Load, then cmd AND key_l=5 key_r=2, SEARCH_LAT=2, CAM model returns row n = n*3: pe regs show 5/2, controller=00, write_en=0; res_valid at T+3; rows 0,3,..,21 in order; res_last with idx 7.
3. During DRAIN, hold res_ready low for 5 cycles at row 4: row 4 stays stable; no rows lost or duplicated; READY follows the row 7 handshake.
4. In READY, assert op_valid and in_valid together: command accepted, in_ready=0, fill count unchanged.
5. cmd op_code=11: op_err is a single pulse, no SEARCH, cam_controller unchanged, op_ready stays 1.
6. Assert rst_n=0 for one cycle mid-DRAIN (row 3) and mid-FILL (count 5): all outputs return to reset values; the next fill restarts at entry 0.
